// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - LC-3b controller memory port to physical memory bridge.
// Optional one-entry read buffer enabled by defining MEM_BRIDGE_RDBUF_EN.
module mem_bridge #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [15:0]       mem_wdata,
  input  logic [1:0]        mem_byte_enable,
  output logic [15:0]       mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [15:0]       pmem_wdata,
  output logic [1:0]        pmem_byte_enable,
  input  logic [15:0]       pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state_q, state_d;
  logic              mem_resp_q, mem_resp_d;
  logic [15:0]       mem_rdata_q, mem_rdata_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic [15:0]       pmem_wdata_q, pmem_wdata_d;
  logic [1:0]        pmem_be_q, pmem_be_d;

  logic [ADDR_W-1:0] word_addr;
  logic              rd_hit;

  assign word_addr = mem_address & ~{{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef MEM_BRIDGE_RDBUF_EN
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_tag_q, buf_tag_d;
  logic [15:0]       buf_data_q, buf_data_d;

  assign rd_hit = buf_valid_q && (buf_tag_q == word_addr);

  // Fill on a completed miss; merge completed writes that land on the buffered word.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    if (state_q == RD && pmem_resp) begin
      buf_valid_d = 1'b1;
      buf_tag_d   = pmem_address_q;
      buf_data_d  = pmem_rdata;
    end else if (state_q == WR && pmem_resp && buf_tag_q == pmem_address_q) begin
      if (pmem_be_q[0]) buf_data_d[7:0]  = pmem_wdata_q[7:0];
      if (pmem_be_q[1]) buf_data_d[15:8] = pmem_wdata_q[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= 16'h0000;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign rd_hit = 1'b0;
`endif

  // Outputs are computed from the next state so they are all registered.
  always_comb begin
    state_d        = state_q;
    mem_resp_d     = 1'b0;
    mem_rdata_d    = mem_rdata_q;
    pmem_read_d    = 1'b0;
    pmem_write_d   = 1'b0;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    pmem_be_d      = pmem_be_q;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          pmem_address_d = word_addr;
          pmem_wdata_d   = mem_wdata;
          pmem_be_d      = mem_byte_enable;
          pmem_write_d   = 1'b1;
          state_d        = WR;
        end else if (mem_read) begin
          pmem_address_d = word_addr;
          pmem_be_d      = 2'b11;
          if (rd_hit) begin
`ifdef MEM_BRIDGE_RDBUF_EN
            mem_rdata_d = buf_data_q;
`endif
            mem_resp_d  = 1'b1;
            state_d     = RESP;
          end else begin
            pmem_read_d = 1'b1;
            state_d     = RD;
          end
        end
      end
      RD: begin
        if (pmem_resp) begin
          mem_rdata_d = pmem_rdata;
          mem_resp_d  = 1'b1;
          state_d     = RESP;
        end else begin
          pmem_read_d = 1'b1;
        end
      end
      WR: begin
        if (pmem_resp) begin
          mem_resp_d = 1'b1;
          state_d    = RESP;
        end else begin
          pmem_write_d = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      mem_resp_q     <= 1'b0;
      mem_rdata_q    <= 16'h0000;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= 16'h0000;
      pmem_be_q      <= 2'b00;
    end else begin
      state_q        <= state_d;
      mem_resp_q     <= mem_resp_d;
      mem_rdata_q    <= mem_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      pmem_be_q      <= pmem_be_d;
    end
  end

  assign mem_resp         = mem_resp_q;
  assign mem_rdata        = mem_rdata_q;
  assign pmem_read        = pmem_read_q;
  assign pmem_write       = pmem_write_q;
  assign pmem_address     = pmem_address_q;
  assign pmem_wdata       = pmem_wdata_q;
  assign pmem_byte_enable = pmem_be_q;

endmodule
